// File: rtl/instr_fetch_queue_if.sv
// Instruction-memory request/response bus between the fetch queue (master) and memory (slave).
// One request outstanding at a time; the response arrives no earlier than the cycle after acceptance.
interface instr_fetch_queue_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/instr_fetch_queue.sv
// RV32I fetch front-end: one-outstanding word fetcher feeding a small (instr, pc) FIFO to decode.
// Redirects from EX flush the FIFO; an empty head is presented as the canonical nop bubble.
module instr_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       redirect,
  input  logic [31:0]                redirect_pc,
  input  logic                       stall,
  instr_fetch_queue_if.master        imem,
  output logic                       instr_valid,
  output logic [31:0]                instr_out,
  output logic [31:0]                pc_out,
  output logic [31:0]                pc_plus4_out
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DROP
  } fetchState_t;

  fetchState_t       stateReg, stateNext;
  logic [31:0]       fetchPcReg, fetchPcNext;
  logic [31:0]       reqPcReg, reqPcNext;
  logic [CNT_W-1:0]  countReg, countNext;
  logic [PTR_W-1:0]  wrPtrReg, wrPtrNext;
  logic [PTR_W-1:0]  rdPtrReg, rdPtrNext;

  logic [31:0]       instrMem [DEPTH];
  logic [31:0]       pcMem    [DEPTH];
  logic [DEPTH-1:0]  wrEn;

  logic              reqFire;
  logic              enqueue;
  logic              dequeue;
  logic [31:0]       headInstr;
  logic [31:0]       headPc;

  // Registered count gates the request, so a slot is always free for the in-flight response.
  assign imem.imem_req  = (stateReg == IDLE) && !redirect && !reset && (countReg < DEPTH_C);
  assign imem.imem_addr = fetchPcReg;
  assign reqFire        = imem.imem_req && imem.imem_ready;

  assign instr_valid = (countReg != '0);
  assign dequeue     = instr_valid && !stall && !redirect;

  always_comb begin
    stateNext   = stateReg;
    fetchPcNext = fetchPcReg;
    reqPcNext   = reqPcReg;
    countNext   = countReg;
    wrPtrNext   = wrPtrReg;
    rdPtrNext   = rdPtrReg;
    enqueue     = 1'b0;

    case (stateReg)
      IDLE: begin
        if (reqFire) begin
          stateNext = WAIT;
        end
      end
      WAIT: begin
        if (imem.imem_rvalid) begin
          stateNext = IDLE;
          enqueue   = !redirect;
        end else if (redirect) begin
          stateNext = DROP;
        end
      end
      DROP: begin
        if (imem.imem_rvalid) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase

    if (reqFire) begin
      reqPcNext   = fetchPcReg;
      fetchPcNext = fetchPcReg + 32'd4;
    end

    if (redirect) begin
      fetchPcNext = redirect_pc;
      countNext   = '0;
      wrPtrNext   = '0;
      rdPtrNext   = '0;
    end else begin
      if (enqueue) begin
        wrPtrNext = wrPtrReg + PTR_W'(1);
      end
      if (dequeue) begin
        rdPtrNext = rdPtrReg + PTR_W'(1);
      end
      case ({enqueue, dequeue})
        2'b10:   countNext = countReg + CNT_W'(1);
        2'b01:   countNext = countReg - CNT_W'(1);
        default: countNext = countReg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg   <= IDLE;
      fetchPcReg <= RESET_PC;
      reqPcReg   <= RESET_PC;
      countReg   <= '0;
      wrPtrReg   <= '0;
      rdPtrReg   <= '0;
    end else begin
      stateReg   <= stateNext;
      fetchPcReg <= fetchPcNext;
      reqPcReg   <= reqPcNext;
      countReg   <= countNext;
      wrPtrReg   <= wrPtrNext;
      rdPtrReg   <= rdPtrNext;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : gWrEn
      assign wrEn[gi] = enqueue && (wrPtrReg == PTR_W'(gi));
    end
  endgenerate

  // Payload storage carries no reset; validity is tracked solely by countReg.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wrEn[i]) begin
        instrMem[i] <= imem.imem_rdata;
        pcMem[i]    <= reqPcReg;
      end
    end
  end

  assign headInstr    = instrMem[rdPtrReg];
  assign headPc       = pcMem[rdPtrReg];
  assign instr_out    = instr_valid ? headInstr : NOP_INSTR;
  assign pc_out       = instr_valid ? headPc : 32'h0;
  assign pc_plus4_out = instr_valid ? (headPc + 32'd4) : 32'h0;

endmodule
